// File: rtl/ddr5_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_cmd_pkg (package)
// Purpose : Definitions shared by the DDR5 CA-bus command encoder, its
//           packing sub-module and the controller FSM:
//           - cmd_op opcode values driven by the controller
//           - 5-bit UI1 opcode patterns placed on CA[4:0]
//           - CA bus width and the encoder state encoding
//           - op_is_legal(): which cmd_op values the encoder accepts
// Revision: 1.0 - initial release
// ============================================================================
package ddr5_cmd_pkg;

    localparam int CA_W = 14;

    // Controller command opcodes (cmd_op)
    localparam logic [3:0] c_op_act = 4'd8;
    localparam logic [3:0] c_op_wr  = 4'd7;
    localparam logic [3:0] c_op_wra = 4'd5;
    localparam logic [3:0] c_op_rd  = 4'd4;
    localparam logic [3:0] c_op_rda = 4'd12;
    localparam logic [3:0] c_op_pre = 4'd13;
    localparam logic [3:0] c_op_ref = 4'd14;

    // UI1 opcode patterns for CA[4:0]
    localparam logic [4:0] c_ui1_wr  = 5'b01101;
    localparam logic [4:0] c_ui1_rd  = 5'b11101;
    localparam logic [4:0] c_ui1_pre = 5'b11011;
    localparam logic [4:0] c_ui1_ref = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UI1  = 2'd1,
        ST_UI2  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            c_op_act, c_op_wr, c_op_wra, c_op_rd,
            c_op_rda, c_op_pre, c_op_ref: op_is_legal = 1'b1;
            default:                      op_is_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr5_ca_pack.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_ca_pack
// Purpose : Combinational packer: command opcode + address fields -> the
//           CA words for UI1 and UI2, plus a flag telling whether the
//           command needs the second UI. Unused CA bits are always 0.
// Ports   : op      in  4      command opcode (cmd_op encoding)
//           bg      in  BG_W   bank group, zero-extended into CA[10:8]
//           ba      in  BA_W   bank, zero-extended into CA[7:6]
//           row     in  ROW_W  row address (ACT)
//           col     in  COL_W  column address (RD/WR), bits above 9 ignored
//           ui1     out 14     CA word for the first UI
//           ui2     out 14     CA word for the second UI (0 for 1-UI ops)
//           two_ui  out 1      op is a 2-UI command
// Revision: 1.0 - initial release
// ============================================================================
module ddr5_ca_pack
    import ddr5_cmd_pkg::*;
#(
    parameter int BG_W  = 3,
    parameter int BA_W  = 2,
    parameter int ROW_W = 16,
    parameter int COL_W = 10
) (
    input  logic [3:0]       op,
    input  logic [BG_W-1:0]  bg,
    input  logic [BA_W-1:0]  ba,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic [CA_W-1:0]  ui1,
    output logic [CA_W-1:0]  ui2,
    output logic             two_ui
);

    logic [2:0] w_bg;
    logic [1:0] w_ba;
    logic [9:0] w_col;
    logic       w_ap_n;
    logic       w_unused_col;

    assign w_bg   = 3'(bg);
    assign w_ba   = 2'(ba);
    assign w_col  = 10'(col);
    // Auto-precharge is active low on the bus: 0 for WRA/RDA.
    assign w_ap_n = !((op == c_op_wra) || (op == c_op_rda));
    assign w_unused_col = ^w_col[1:0];

    always_comb begin
        ui1    = '0;
        ui2    = '0;
        two_ui = 1'b0;
        case (op)
            c_op_act: begin
                ui1[5:2]  = row[3:0];
                ui1[7:6]  = w_ba;
                ui1[10:8] = w_bg;
                // Upper row bits land from CA[0] upward in UI2.
                for (int i = 4; i < ROW_W; i++) begin
                    ui2[i-4] = row[i];
                end
                two_ui = 1'b1;
            end
            c_op_wr, c_op_wra: begin
                ui1[4:0]  = c_ui1_wr;
                ui1[7:6]  = w_ba;
                ui1[10:8] = w_bg;
                ui2[0]    = 1'b1;
                ui2[7:1]  = w_col[9:3];
                ui2[9]    = 1'b1;
                ui2[10]   = w_ap_n;
                ui2[12]   = 1'b1;
                two_ui    = 1'b1;
            end
            c_op_rd, c_op_rda: begin
                ui1[4:0]  = c_ui1_rd;
                ui1[7:6]  = w_ba;
                ui1[10:8] = w_bg;
                ui2[7:0]  = w_col[9:2];
                ui2[9]    = 1'b1;
                ui2[10]   = w_ap_n;
                ui2[11]   = 1'b1;
                ui2[12]   = 1'b1;
                two_ui    = 1'b1;
            end
            c_op_pre: begin
                ui1[4:0]  = c_ui1_pre;
                ui1[7:6]  = w_ba;
                ui1[10:8] = w_bg;
            end
            c_op_ref: begin
                ui1[4:0]  = c_ui1_ref;
            end
            default: begin
                ui1 = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ddr5_ca_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_ca_cmd_encoder
// Purpose : DDR5 CA-bus command encoder between scheduler and PHY. Takes one
//           command per valid/ready handshake, emits a 1-UI (PRE, REF) or
//           2-UI (ACT, RD, RDA, WR, WRA) packet on CS_o/CA, then holds the
//           bus idle for CMD_GAP cycles. Illegal opcodes are accepted,
//           dropped, and flagged with a one-cycle err_op pulse.
// Config  : DDR5_CA_PARITY_EN - adds CA_par, even parity of CA, registered
//           with CA (0 when idle and in reset).
// Ports   : clk        in  1      clock, posedge
//           rst        in  1      synchronous active-high reset
//           cmd_valid  in  1      command present
//           cmd_ready  out 1      high only in IDLE and out of reset
//           cmd_op     in  4      command opcode
//           BG/BA      in  BG_W/BA_W  bank group / bank
//           row        in  ROW_W  row address
//           col        in  COL_W  column address
//           CS_o       out 1      chip select, active low in UI1
//           CA         out 14     command/address bus
//           busy       out 1      packet or gap in progress
//           CA_par     out 1      CA parity (DDR5_CA_PARITY_EN only)
//           err_op     out 1      illegal op accepted and dropped
// Revision: 1.0 - initial release
// ============================================================================
module ddr5_ca_cmd_encoder
    import ddr5_cmd_pkg::*;
#(
    parameter int BG_W    = 3,
    parameter int BA_W    = 2,
    parameter int ROW_W   = 16,
    parameter int COL_W   = 10,
    parameter int CMD_GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [BG_W-1:0]  BG,
    input  logic [BA_W-1:0]  BA,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic             CS_o,
    output logic [CA_W-1:0]  CA,
    output logic             busy,
`ifdef DDR5_CA_PARITY_EN
    output logic             CA_par,
`endif
    output logic             err_op
);

    // GAP is entered already counting its first cycle.
    localparam logic [3:0] c_gap_load = (CMD_GAP > 0) ? 4'(CMD_GAP - 1) : 4'd0;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_gap_cnt;
    logic [3:0]        w_next_gap_cnt;
    logic              w_next_cs;
    logic [CA_W-1:0]   w_next_ca;
    logic              w_xfer;
    logic              w_legal;

    logic [3:0]        r_op;
    logic [BG_W-1:0]   r_bg;
    logic [BA_W-1:0]   r_ba;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;

    logic              r_cs;
    logic [CA_W-1:0]   r_ca;
    logic              r_err;

    logic [CA_W-1:0]   w_ui1;
    logic [CA_W-1:0]   w_ui2;
    logic              w_two_ui;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_legal   = op_is_legal(cmd_op);

    // Packing works from the holding register so the address inputs are
    // free to change as soon as the handshake completes.
    ddr5_ca_pack #(
        .BG_W  (BG_W),
        .BA_W  (BA_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pack (
        .op     (r_op),
        .bg     (r_bg),
        .ba     (r_ba),
        .row    (r_row),
        .col    (r_col),
        .ui1    (w_ui1),
        .ui2    (w_ui2),
        .two_ui (w_two_ui)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_gap_cnt = r_gap_cnt;
        w_next_cs      = 1'b1;
        w_next_ca      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && w_legal) begin
                    w_next_state = ST_UI1;
                end
            end
            ST_UI1: begin
                w_next_cs = 1'b0;
                w_next_ca = w_ui1;
                if (w_two_ui) begin
                    w_next_state = ST_UI2;
                end else if (CMD_GAP == 0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state   = ST_GAP;
                    w_next_gap_cnt = c_gap_load;
                end
            end
            ST_UI2: begin
                w_next_ca = w_ui2;
                if (CMD_GAP == 0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state   = ST_GAP;
                    w_next_gap_cnt = c_gap_load;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_gap_cnt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 4'd0;
            r_cs      <= 1'b1;
            r_ca      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_next_gap_cnt;
            r_cs      <= w_next_cs;
            r_ca      <= w_next_ca;
            r_err     <= w_xfer && !w_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_op  <= cmd_op;
            r_bg  <= BG;
            r_ba  <= BA;
            r_row <= row;
            r_col <= col;
        end
    end

`ifdef DDR5_CA_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ^w_next_ca;
        end
    end

    assign CA_par = r_par;
`endif

    assign CS_o   = r_cs;
    assign CA     = r_ca;
    assign err_op = r_err;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr5_ca_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr5_ca_cmd_encoder
// Purpose : Self-checking bench for ddr5_ca_cmd_encoder (CMD_GAP=2). A
//           cycle model decides when each command transfers and pushes the
//           expected per-cycle CS_o/CA sequence into a scoreboard queue;
//           a monitor pops and compares on every falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ddr5_ca_cmd_encoder;

    localparam int GAP = 2;

    localparam logic [3:0] OP_ACT = 4'd8;
    localparam logic [3:0] OP_WR  = 4'd7;
    localparam logic [3:0] OP_WRA = 4'd5;
    localparam logic [3:0] OP_RD  = 4'd4;
    localparam logic [3:0] OP_RDA = 4'd12;
    localparam logic [3:0] OP_PRE = 4'd13;
    localparam logic [3:0] OP_REF = 4'd14;

    typedef struct {
        logic        cs;
        logic [13:0] ca;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [2:0]  bg = 3'd0;
    logic [1:0]  ba = 2'd0;
    logic [15:0] row = 16'd0;
    logic [9:0]  col = 10'd0;
    logic        cs_o;
    logic [13:0] ca;
    logic        busy;
    logic        err_op;
`ifdef DDR5_CA_PARITY_EN
    logic        ca_par;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   busy_cnt = 0;
    logic pend_err = 1'b0;
    logic prev_rst = 1'b0;
    logic xfer_flag = 1'b0;

    ddr5_ca_cmd_encoder #(
        .BG_W    (3),
        .BA_W    (2),
        .ROW_W   (16),
        .COL_W   (10),
        .CMD_GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .BG        (bg),
        .BA        (ba),
        .row       (row),
        .col       (col),
        .CS_o      (cs_o),
        .CA        (ca),
        .busy      (busy),
`ifdef DDR5_CA_PARITY_EN
        .CA_par    (ca_par),
`endif
        .err_op    (err_op)
    );

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_ACT) || (op == OP_WR) || (op == OP_WRA) || (op == OP_RD) ||
               (op == OP_RDA) || (op == OP_PRE) || (op == OP_REF);
    endfunction

    function automatic logic is_two(input logic [3:0] op);
        return (op == OP_ACT) || (op == OP_WR) || (op == OP_WRA) || (op == OP_RD) || (op == OP_RDA);
    endfunction

    function automatic logic [13:0] m_ui1(input logic [3:0] op, input logic [2:0] g,
                                          input logic [1:0] b, input logic [15:0] r);
        case (op)
            OP_ACT:         return {3'b000, g, b, r[3:0], 2'b00};
            OP_WR, OP_WRA:  return {3'b000, g, b, 1'b0, 5'b01101};
            OP_RD, OP_RDA:  return {3'b000, g, b, 1'b0, 5'b11101};
            OP_PRE:         return {3'b000, g, b, 1'b0, 5'b11011};
            OP_REF:         return {9'd0, 5'b10011};
            default:        return 14'd0;
        endcase
    endfunction

    function automatic logic [13:0] m_ui2(input logic [3:0] op, input logic [15:0] r,
                                          input logic [9:0] c);
        case (op)
            OP_ACT: return {2'b00, r[15:4]};
            OP_WR:  return {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c[9:3], 1'b1};
            OP_WRA: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c[9:3], 1'b1};
            OP_RD:  return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c[9:2]};
            OP_RDA: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c[9:2]};
            default: return 14'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor + model, evaluated away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic m_ready;
        if (rst) begin
            chk("ready_in_rst", 16'(cmd_ready), 16'd0);
            if (prev_rst) begin
                chk("rst_cs", 16'(cs_o), 16'd1);
                chk("rst_ca", 16'(ca), 16'd0);
                chk("rst_busy", 16'(busy), 16'd0);
                chk("rst_err", 16'(err_op), 16'd0);
`ifdef DDR5_CA_PARITY_EN
                chk("rst_par", 16'(ca_par), 16'd0);
`endif
            end
            sb.delete();
            busy_cnt = 0;
            pend_err = 1'b0;
        end else begin
            if (sb.size() > 0) e = sb.pop_front();
            else begin
                e.cs = 1'b1;
                e.ca = 14'd0;
            end
            m_ready = (busy_cnt == 0);
            chk("cs", 16'(cs_o), 16'(e.cs));
            chk("ca", 16'(ca), 16'(e.ca));
`ifdef DDR5_CA_PARITY_EN
            chk("par", 16'(ca_par), 16'(^e.ca));
`endif
            chk("err_op", 16'(err_op), 16'(pend_err));
            chk("cmd_ready", 16'(cmd_ready), 16'(m_ready));
            chk("busy", 16'(busy), 16'(!m_ready));
            pend_err = 1'b0;
            if (cmd_valid && m_ready) begin
                xfer_flag = 1'b1;
                if (is_legal(cmd_op)) begin
                    sb.push_back('{cs: 1'b1, ca: 14'd0});
                    sb.push_back('{cs: 1'b0, ca: m_ui1(cmd_op, bg, ba, row)});
                    if (is_two(cmd_op))
                        sb.push_back('{cs: 1'b1, ca: m_ui2(cmd_op, row, col)});
                    for (int i = 0; i < GAP; i++)
                        sb.push_back('{cs: 1'b1, ca: 14'd0});
                    busy_cnt = (is_two(cmd_op) ? 2 : 1) + GAP;
                end else begin
                    pend_err = 1'b1;
                end
            end else if (busy_cnt != 0) begin
                busy_cnt--;
            end
        end
        prev_rst = rst;
    end

    // Present one command and hold it until the model sees it transfer.
    task automatic send(input logic [3:0] op, input logic [2:0] g, input logic [1:0] b,
                        input logic [15:0] r, input logic [9:0] c);
        logic done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        bg = g;
        ba = b;
        row = r;
        col = c;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            if (xfer_flag) begin
                xfer_flag = 1'b0;
                done = 1'b1;
            end
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL send_timeout op=%0d observed=no_transfer expected=transfer", op);
        end
        #1;
        cmd_valid = 1'b0;
        bg = 3'd0;
        ba = 2'd0;
        row = 16'hFFFF;
        col = 10'h3FF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Reset asserted mid-WR, right before UI2 would go out.
        send(OP_WR, 3'd3, 2'd1, 16'd0, 10'h155);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // ACT BG=5 BA=2 row=ABCD.
        send(OP_ACT, 3'd5, 2'd2, 16'hABCD, 10'd0);
        idle(8);

        // RDA with auto-precharge, then the gap.
        send(OP_RDA, 3'd1, 2'd1, 16'd0, 10'h3FC);
        idle(8);

        // WRA col=0, RD and WR with mixed fields, back to back.
        send(OP_WRA, 3'd0, 2'd0, 16'd0, 10'd0);
        send(OP_RD,  3'd6, 2'd3, 16'd0, 10'h2AA);
        send(OP_WR,  3'd7, 2'd2, 16'd0, 10'h0F8);
        idle(8);

        // Back-to-back PRE then REF with valid held high.
        send(OP_PRE, 3'd2, 2'd3, 16'd0, 10'd0);
        send(OP_REF, 3'd0, 2'd0, 16'd0, 10'd0);
        idle(8);

        // Illegal op, then a legal one on the next cycle.
        send(4'd3, 3'd4, 2'd1, 16'h1234, 10'h111);
        send(OP_ACT, 3'd1, 2'd0, 16'h0F0F, 10'd0);
        idle(8);

        // Another illegal op from idle.
        send(4'd0, 3'd0, 2'd0, 16'd0, 10'd0);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
